// File: rtl/dff_pkg.sv
// Shared types for the DFF stage and its downstream consumers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dff_pkg;

  // Debouncer FSM states: two settled levels and two qualifying states.
  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } debounce_state_t;

  // Largest STABLE_CYCLES a debouncer accepts; checked at elaboration.
  localparam int DEBOUNCE_MAX_CYCLES = 65535;

endpackage

// File: rtl/dff_debounce_edge.sv
// Purpose: debounce the registered DFF output; emit clean level plus rise/fall pulses.
// Latency: level updates on the edge taking the STABLE_CYCLES-th matching enabled sample; pulses follow for one cycle.
// Backpressure: none; en=0 freezes state and counter and suppresses pulses.
//
// Ports:
//   clk   - clock, all state on posedge
//   rst   - synchronous active-high reset, wins over en/din
//   din   - registered bit from the upstream DFF stage
//   en    - sample enable
//   level - debounced level
//   rise  - one-cycle pulse on level 0->1
//   fall  - one-cycle pulse on level 1->0
//   busy  - high while a candidate transition is being qualified
//
// Optional build macro: DFF_DEBOUNCE_ASSERT_EN compiles in SVA protocol checks.
module dff_debounce_edge
  import dff_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single required sample there is nothing to qualify: accept directly.
  localparam bit SINGLE = (STABLE_CYCLES == 1);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > DEBOUNCE_MAX_CYCLES) begin : g_bad_param
    $error("dff_debounce_edge: STABLE_CYCLES=%0d outside 1..%0d",
           STABLE_CYCLES, DEBOUNCE_MAX_CYCLES);
  end

  debounce_state_t state;
  logic [CNT_W-1:0] cnt;

  // cnt holds the number of matching samples already taken for the
  // candidate, so the candidate is accepted when the sample arriving with
  // cnt == STABLE_CYCLES-1 also matches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        case (state)
          IDLE_LO: begin
            if (din) begin
              if (SINGLE) begin
                state <= IDLE_HI;
                level <= 1'b1;
                rise  <= 1'b1;
              end else begin
                state <= CHK_HI;
                cnt   <= CNT_ONE;
                busy  <= 1'b1;
              end
            end
          end
          CHK_HI: begin
            if (!din) begin
              state <= IDLE_LO;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE_HI;
              cnt   <= '0;
              level <= 1'b1;
              rise  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          IDLE_HI: begin
            if (!din) begin
              if (SINGLE) begin
                state <= IDLE_LO;
                level <= 1'b0;
                fall  <= 1'b1;
              end else begin
                state <= CHK_LO;
                cnt   <= CNT_ONE;
                busy  <= 1'b1;
              end
            end
          end
          CHK_LO: begin
            if (din) begin
              state <= IDLE_HI;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE_LO;
              cnt   <= '0;
              level <= 1'b0;
              fall  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DFF_DEBOUNCE_ASSERT_EN
  a_rise_level: assert property (@(posedge clk) disable iff (rst) rise |-> level)
    $info("[%0t] a_rise_level pass", $time);
  else $error("[%0t] a_rise_level: rise without level", $time);

  a_fall_level: assert property (@(posedge clk) disable iff (rst) fall |-> !level)
    $info("[%0t] a_fall_level pass", $time);
  else $error("[%0t] a_fall_level: fall with level high", $time);

  a_one_hot: assert property (@(posedge clk) disable iff (rst) !(rise && fall))
    $info("[%0t] a_one_hot pass", $time);
  else $error("[%0t] a_one_hot: rise and fall together", $time);

  a_rose_pulse: assert property (@(posedge clk) disable iff (rst) $rose(level) |-> rise)
    $info("[%0t] a_rose_pulse pass", $time);
  else $error("[%0t] a_rose_pulse: level rose without rise", $time);

  // A reset-forced 1->0 drop is silent by design, so skip the edge after reset.
  a_fell_pulse: assert property (@(posedge clk) disable iff (rst)
                                 ($fell(level) && !$past(rst)) |-> fall)
    $info("[%0t] a_fell_pulse pass", $time);
  else $error("[%0t] a_fell_pulse: level fell without fall", $time);

  a_busy_cnt: assert property (@(posedge clk) disable iff (rst)
                               busy |-> (int'(cnt) < STABLE_CYCLES))
    $info("[%0t] a_busy_cnt pass", $time);
  else $error("[%0t] a_busy_cnt: counter out of range", $time);

  a_en_hold: assert property (@(posedge clk) disable iff (rst) !en |=> $stable(level))
    $info("[%0t] a_en_hold pass", $time);
  else $error("[%0t] a_en_hold: level moved while disabled", $time);
`endif

endmodule

// File: tb/tb_dff_debounce_edge.sv
// Bench for dff_debounce_edge: directed vector table on a 4-sample instance,
// a toggle sequence on a 1-sample instance, then random traffic on both.
module tb_dff_debounce_edge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en4, din4, level4, rise4, fall4, busy4;
  logic en1, din1, level1, rise1, fall1, busy1;

  dff_debounce_edge #(.STABLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din4), .en(en4),
    .level(level4), .rise(rise4), .fall(fall4), .busy(busy4)
  );

  dff_debounce_edge #(.STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din1), .en(en1),
    .level(level1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, en, din;
    logic level, rise, fall, busy;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl[NV];

  task automatic setv(input int i, input logic [6:0] b);
    tbl[i].rst   = b[6];
    tbl[i].en    = b[5];
    tbl[i].din   = b[4];
    tbl[i].level = b[3];
    tbl[i].rise  = b[2];
    tbl[i].fall  = b[1];
    tbl[i].busy  = b[0];
  endtask

  // Reference model: count consecutive enabled samples that disagree with the
  // accepted level; once N of them have been seen, flip the level and pulse.
  int   m_n[2] = '{4, 1};
  int   m_run[2];
  logic m_level[2], m_rise[2], m_fall[2];

  task automatic model(input int k, input logic r, input logic e, input logic d);
    m_rise[k] = 1'b0;
    m_fall[k] = 1'b0;
    if (r) begin
      m_level[k] = 1'b0;
      m_run[k]   = 0;
    end else if (e) begin
      if (d != m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == m_n[k]) begin
          m_level[k] = d;
          m_rise[k]  = d;
          m_fall[k]  = !d;
          m_run[k]   = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  initial begin
    // rst en din | level rise fall busy
    setv( 0, 7'b110_0000); setv( 1, 7'b110_0000);           // reset with din=1
    setv( 2, 7'b011_0001); setv( 3, 7'b011_0001);           // clean rise
    setv( 4, 7'b011_0001); setv( 5, 7'b011_1100);
    setv( 6, 7'b011_1000);
    setv( 7, 7'b010_1001); setv( 8, 7'b010_1001);           // clean fall
    setv( 9, 7'b010_1001); setv(10, 7'b010_0010);
    setv(11, 7'b010_0000);
    setv(12, 7'b011_0001); setv(13, 7'b011_0001);           // 3-cycle glitch
    setv(14, 7'b011_0001); setv(15, 7'b010_0000);
    setv(16, 7'b010_0000);
    setv(17, 7'b011_0001); setv(18, 7'b001_0001);           // en 1,0,1,0,1,1
    setv(19, 7'b011_0001); setv(20, 7'b001_0001);
    setv(21, 7'b011_0001); setv(22, 7'b011_1100);
    setv(23, 7'b001_1000);
    setv(24, 7'b010_1001); setv(25, 7'b010_1001);           // CHK_LO, cnt=2
    setv(26, 7'b110_0000); setv(27, 7'b010_0000);           // reset abandons it
    setv(28, 7'b101_0000);                                  // rst beats en/din

    rst = 1'b1; en4 = 1'b0; din4 = 1'b0; en1 = 1'b0; din1 = 1'b0;
    #2;

    for (int i = 0; i < NV; i++) begin
      rst  = tbl[i].rst;
      en4  = tbl[i].en;
      din4 = tbl[i].din;
      step();
      chk($sformatf("vec%0d.level", i), level4, tbl[i].level);
      chk($sformatf("vec%0d.rise",  i), rise4,  tbl[i].rise);
      chk($sformatf("vec%0d.fall",  i), fall4,  tbl[i].fall);
      chk($sformatf("vec%0d.busy",  i), busy4,  tbl[i].busy);
    end

    // Single-sample instance: level tracks din one edge later, pulses alternate.
    rst = 1'b1; en1 = 1'b1; din1 = 1'b1;
    step();
    chk("n1.reset.level", level1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din1 = (i % 2 == 0);
      step();
      chk($sformatf("n1.tog%0d.level", i), level1, din1);
      chk($sformatf("n1.tog%0d.rise",  i), rise1,  din1);
      chk($sformatf("n1.tog%0d.fall",  i), fall1,  !din1);
      chk($sformatf("n1.tog%0d.busy",  i), busy1,  1'b0);
    end

    // Random traffic on both instances, starting from a reset so the model aligns.
    for (int c = 0; c < 400; c++) begin
      rst  = (c == 0) || ($urandom_range(0, 39) == 0);
      en4  = ($urandom_range(0, 3) != 0);
      en1  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) din4 = ~din4;
      din1 = 1'($urandom_range(0, 1));
      model(0, rst, en4, din4);
      model(1, rst, en1, din1);
      step();
      chk($sformatf("rnd%0d.n4.level", c), level4, m_level[0]);
      chk($sformatf("rnd%0d.n4.rise",  c), rise4,  m_rise[0]);
      chk($sformatf("rnd%0d.n4.fall",  c), fall4,  m_fall[0]);
      chk($sformatf("rnd%0d.n4.busy",  c), busy4,  m_run[0] != 0);
      chk($sformatf("rnd%0d.n1.level", c), level1, m_level[1]);
      chk($sformatf("rnd%0d.n1.rise",  c), rise1,  m_rise[1]);
      chk($sformatf("rnd%0d.n1.fall",  c), fall1,  m_fall[1]);
      chk($sformatf("rnd%0d.n1.busy",  c), busy1,  m_run[1] != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dff_debounce_edge.md
Name: dff_debounce_edge

Overview:
Downstream consumer of the registered single-bit output of the team's D flip-flop stage (dout). Filters the registered bit so that only levels held for STABLE_CYCLES consecutive enabled cycles are accepted. Emits a clean level plus single-cycle rise and fall pulses for control logic further downstream. Pure synchronous logic on clk; no CDC. The input is already registered upstream.

Parameters:
STABLE_CYCLES, 4, consecutive enabled samples of a new value required to accept it; legal range 1..65535.
CNT_W, $clog2(STABLE_CYCLES+1), stability counter width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset, synchronous, active-high.
din  input  1  registered bit from the upstream DFF stage.
en   input  1  sample enable; when low, state and counter are frozen.
level  output  1  debounced level.
rise  output  1  one-cycle pulse when level goes 0->1.
fall  output  1  one-cycle pulse when level goes 1->0.
busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- All outputs are registered.
- Reset (rst high at posedge): state=IDLE_LO, cnt=0, level=0, rise=0, fall=0, busy=0.
  - rst has priority over en/din.
  - No fall pulse is generated when reset forces level from 1 to 0.
- FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO. busy=1 exactly in CHK_HI/CHK_LO (registered with state).
- A cycle with en=0:
  - No state or cnt change, and rise=fall=0.
  - Neither counts as a sample nor breaks a run.
- IDLE_LO, en=1, din=1:
  - STABLE_CYCLES=1: go to IDLE_HI, level<=1, rise<=1.
  - Otherwise: go to CHK_HI, cnt<=1.
- CHK_HI, en=1:
  - din=0: return to IDLE_LO, cnt<=0. Glitch rejected, no pulse.
  - din=1 and cnt==STABLE_CYCLES-1: go to IDLE_HI, cnt<=0, level<=1, rise<=1.
  - din=1 otherwise: cnt<=cnt+1.
- IDLE_HI/CHK_LO: mirror of the above with din polarity inverted; produces fall instead of rise.
- Latency: level changes at the posedge that takes the STABLE_CYCLES-th consecutive enabled matching sample. rise/fall are high for exactly the following cycle.
- rise and fall are never high together. At most one pulse per STABLE_CYCLES enabled cycles.
- A din equal to the current level in IDLE_* is ignored.
- cnt never exceeds STABLE_CYCLES-1; no wrap-around possible.
- rst asserted mid-CHK: the candidate is abandoned and the next cycle is IDLE_LO.

Optional Feature:
DFF_DEBOUNCE_ASSERT_EN.
- Defined: compiles in concurrent SVA checks on posedge clk, disabled iff rst:
  - rise|->level.
  - fall|->!level.
  - !(rise&&fall).
  - $rose(level)|->rise.
  - $fell(level)|->fall.
  - busy|->(cnt<STABLE_CYCLES).
  - !en|=>$stable(level).
  - Each check has labelled pass/fail messages via $info/$error with $time.
- Undefined: no assertion code is present; RTL behaviour is identical.

Decomposition:
- Shared package dff_pkg holds:
  - typedef enum logic [1:0] debounce_state_t {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO}.
  - localparam DEBOUNCE_MAX_CYCLES=65535, used for parameter range checking at elaboration.
- No sub-module. The counter and FSM are small and tightly coupled, so both stay inline in one module.

Test Plan:
- Reset: rst=1 for 2 cycles with din=1 -> level=0, rise=0, fall=0, busy=0 throughout.
- Clean rise (STABLE_CYCLES=4): en=1, din 0->1 held.
  - level=1 after the 4th high sample.
  - rise=1 for exactly 1 cycle.
  - busy high for the 3 preceding cycles.
- Glitch rejection: din high for 3 cycles then 0 -> level stays 0, no rise, busy returns to 0.
- Enable gating: din=1 with en toggling 1,0,1,0,1,1 -> level=1 only after the 4th enabled sample; no pulse during en=0.
- Fall and reset mid-check:
  - From level=1, din=0 for 4 cycles -> fall pulse once, level=0.
  - Separately, rst during CHK_LO at cnt=2 -> level=0, no fall pulse.
- STABLE_CYCLES=1: din toggles every cycle -> level follows din with 1 cycle of latency; rise/fall alternate each cycle.
